// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a valid/ready push FIFO. The frame format is latched
// per word. Break generation and a clean enable/flush are included.
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    output logic                        tx_o,
    output logic                        busy_o,
    input  logic                        cfg_en_i,
    input  logic [DIV_W-1:0]            cfg_div_i,
    input  logic                        cfg_parity_en_i,
    input  logic                        cfg_parity_odd_i,
    input  logic [1:0]                  cfg_bits_i,
    input  logic                        cfg_stop_bits_i,
    input  logic                        cfg_break_i,
    input  logic [7:0]                  tx_data_i,
    input  logic                        tx_valid_i,
    output logic                        tx_ready_o,
    input  logic                        fifo_clr_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        tx_empty_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5,
        BREAK  = 3'd6
    } state_e;

    // FIFO storage and pointers
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_full, fifo_empty, push, pop;
    logic [7:0]    pop_data;

    // Transmit engine state and per-frame latched configuration
    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, cnt_next;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       bits_q, bits_d;
    logic             par_en_q, par_en_d;
    logic             par_q, par_d;
    logic             stop2_q, stop2_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             tx_empty_q, tx_empty_d;
    logic             bit_end, frame_end, par_calc;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign tx_ready_o = cfg_en_i && !fifo_full;
    assign push       = tx_valid_i && tx_ready_o && !fifo_clr_i;
    assign pop_data   = mem_q[rd_ptr_q];

    // Parity over only the data bits that will actually be sent
    assign par_calc = (^(pop_data & (8'hFF >> (2'd3 - cfg_bits_i)))) ^ cfg_parity_odd_i;

    assign bit_end  = (cnt_q == div_q);
    assign cnt_next = bit_end ? '0 : cnt_q + DIV_W'(1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= tx_data_i;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        div_d      = div_q;
        bits_d     = bits_q;
        par_en_d   = par_en_q;
        par_d      = par_q;
        stop2_d    = stop2_q;
        pop        = 1'b0;
        frame_end  = 1'b0;
        tx_d       = 1'b1;

        if (!cfg_en_i) begin
            state_d   = IDLE;
            bit_idx_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_break_i)      state_d = BREAK;
                    else if (!fifo_empty) pop     = 1'b1;
                end
                START: begin
                    cnt_d = cnt_next;
                    if (bit_end) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
                DATA: begin
                    cnt_d = cnt_next;
                    if (bit_end) begin
                        shift_d = {1'b1, shift_q[7:1]};
                        if (bit_idx_q == 3'(bits_q) + 3'd4) state_d = par_en_q ? PARITY : STOP1;
                        else                                bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                PARITY: begin
                    cnt_d = cnt_next;
                    if (bit_end) state_d = STOP1;
                end
                STOP1: begin
                    cnt_d = cnt_next;
                    if (bit_end) begin
                        if (stop2_q) state_d   = STOP2;
                        else         frame_end = 1'b1;
                    end
                end
                STOP2: begin
                    cnt_d = cnt_next;
                    if (bit_end) frame_end = 1'b1;
                end
                BREAK: begin
                    // Closing stop bit uses the live divider, single stop bit
                    if (!cfg_break_i) begin
                        state_d = STOP1;
                        div_d   = cfg_div_i;
                        stop2_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (frame_end) begin
                if (!fifo_empty && !cfg_break_i) pop     = 1'b1;
                else                             state_d = IDLE;
            end

            if (pop) begin
                state_d  = START;
                cnt_d    = '0;
                shift_d  = pop_data;
                div_d    = cfg_div_i;
                bits_d   = cfg_bits_i;
                par_en_d = cfg_parity_en_i;
                par_d    = par_calc;
                stop2_d  = cfg_stop_bits_i;
            end
        end

        case (state_d)
            START, BREAK: tx_d = 1'b0;
            DATA:         tx_d = shift_d[0];
            PARITY:       tx_d = par_d;
            default:      tx_d = 1'b1;
        endcase
    end

    assign busy_d     = (state_d != IDLE);
    assign tx_empty_d = (count_d == '0) && (state_d == IDLE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '1;
            div_q      <= '0;
            bits_q     <= '0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            tx_empty_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            bits_q     <= bits_d;
            par_en_q   <= par_en_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            tx_empty_q <= tx_empty_d;
        end
    end

    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign fifo_count_o = count_q;
    assign tx_empty_o   = tx_empty_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a line-level model (queue of expected tx levels and
// a byte queue) checked every cycle, plus directed scenarios with literal frames.
module tb_uart_tx_fifo;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 16;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          tx_o, busy_o, tx_ready_o, tx_empty_o;
    logic          cfg_en_i = 1'b1;
    logic [DW-1:0] cfg_div_i = 16'd3;
    logic          cfg_parity_en_i = 1'b0;
    logic          cfg_parity_odd_i = 1'b0;
    logic [1:0]    cfg_bits_i = 2'd3;
    logic          cfg_stop_bits_i = 1'b0;
    logic          cfg_break_i = 1'b0;
    logic [7:0]    tx_data_i = 8'h00;
    logic          tx_valid_i = 1'b0;
    logic          fifo_clr_i = 1'b0;
    logic [3:0]    fifo_count_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    bit cap [64];

    // Model state
    bit         line [$];
    logic [7:0] mfifo [$];
    bit         m_busy = 1'b0;
    bit         m_brk = 1'b0;
    bit         m_tx = 1'b1;

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .tx_o(tx_o), .busy_o(busy_o),
        .cfg_en_i(cfg_en_i), .cfg_div_i(cfg_div_i),
        .cfg_parity_en_i(cfg_parity_en_i), .cfg_parity_odd_i(cfg_parity_odd_i),
        .cfg_bits_i(cfg_bits_i), .cfg_stop_bits_i(cfg_stop_bits_i),
        .cfg_break_i(cfg_break_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o), .fifo_clr_i(fifo_clr_i),
        .fifo_count_o(fifo_count_o), .tx_empty_o(tx_empty_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add_level(input bit lvl, input int n);
        for (int i = 0; i < n; i++) line.push_back(lvl);
    endfunction

    function automatic void build_frame(input logic [7:0] w);
        int n;
        int nb;
        bit p;
        n  = int'(cfg_div_i) + 1;
        nb = int'(cfg_bits_i) + 5;
        p  = cfg_parity_odd_i;
        add_level(1'b0, n);
        for (int i = 0; i < nb; i++) begin
            add_level(w[i], n);
            p = p ^ w[i];
        end
        if (cfg_parity_en_i) add_level(p, n);
        add_level(1'b1, n);
        if (cfg_stop_bits_i) add_level(1'b1, n);
    endfunction

    // Model step: decides what the line does in the cycle after this edge
    always @(posedge clk_i or negedge rstn_i) begin : model_step
        bit push;
        if (!rstn_i) begin
            line.delete();
            mfifo.delete();
            m_busy = 1'b0;
            m_brk  = 1'b0;
            m_tx   = 1'b1;
        end else begin
            push = tx_valid_i && cfg_en_i && (mfifo.size() < DEPTH);
            if (!cfg_en_i) begin
                line.delete();
                m_busy = 1'b0;
                m_brk  = 1'b0;
                m_tx   = 1'b1;
            end else if (m_brk) begin
                if (cfg_break_i) m_tx = 1'b0;
                else begin
                    add_level(1'b1, int'(cfg_div_i) + 1);
                    m_brk = 1'b0;
                    m_tx  = line.pop_front();
                end
            end else if (line.size() > 0) begin
                m_tx = line.pop_front();
            end else if (m_busy && (mfifo.size() == 0 || cfg_break_i)) begin
                m_busy = 1'b0;
                m_tx   = 1'b1;
            end else if (!m_busy && cfg_break_i) begin
                m_brk  = 1'b1;
                m_busy = 1'b1;
                m_tx   = 1'b0;
            end else if (mfifo.size() > 0) begin
                build_frame(mfifo.pop_front());
                m_busy = 1'b1;
                m_tx   = line.pop_front();
            end else begin
                m_tx = 1'b1;
            end
            if (fifo_clr_i) mfifo.delete();
            else if (push)  mfifo.push_back(tx_data_i);
        end
    end

    always @(negedge clk_i) begin
        if (rstn_i && chk_en) begin
            check("cyc_tx_o", int'(tx_o), int'(m_tx));
            check("cyc_busy_o", int'(busy_o), int'(m_busy));
            check("cyc_fifo_count_o", int'(fifo_count_o), mfifo.size());
            check("cyc_tx_empty_o", int'(tx_empty_o), int'(mfifo.size() == 0 && !m_busy));
            check("cyc_tx_ready_o", int'(tx_ready_o), int'(cfg_en_i && mfifo.size() < DEPTH));
        end
    end

    task automatic push_word(input logic [7:0] d);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        @(posedge clk_i); #1;
        tx_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (!tx_empty_o && t < 30000) begin
            @(posedge clk_i); #1;
            t++;
        end
        if (!tx_empty_o) check({name, "_idle_timeout"}, 0, 1);
    endtask

    task automatic capture(input string name, input int n);
        int t = 0;
        while (t < 3000) begin
            @(negedge clk_i);
            if (busy_o) break;
            t++;
        end
        if (!busy_o) check({name, "_start_timeout"}, 0, 1);
        cap[0] = tx_o;
        for (int i = 1; i < n; i++) begin
            @(negedge clk_i);
            cap[i] = tx_o;
        end
    endtask

    task automatic check_frame(input string name, input logic [15:0] expv, input int nb, input int per);
        for (int k = 0; k < nb; k++) begin
            int lvl;
            lvl = int'(cap[k*per]);
            for (int j = 1; j < per; j++) if (cap[k*per+j] != cap[k*per]) lvl = 2;
            check($sformatf("%s_bit%0d", name, k), lvl, int'(expv[k]));
        end
    endtask

    task automatic set_cfg(input int div, input logic [1:0] bits, input bit pen, input bit podd, input bit st2);
        cfg_div_i        = DW'(div);
        cfg_bits_i       = bits;
        cfg_parity_en_i  = pen;
        cfg_parity_odd_i = podd;
        cfg_stop_bits_i  = st2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int t_start;
        int t_end;
        int zeros;
        int ones;

        // Reset state
        repeat (3) @(posedge clk_i); #1;
        check("rst_tx_o", int'(tx_o), 1);
        check("rst_busy_o", int'(busy_o), 0);
        check("rst_fifo_count_o", int'(fifo_count_o), 0);
        check("rst_tx_empty_o", int'(tx_empty_o), 1);
        check("rst_tx_ready_en1", int'(tx_ready_o), 1);
        cfg_en_i = 1'b0; #1;
        check("rst_tx_ready_en0", int'(tx_ready_o), 0);
        cfg_en_i = 1'b1;
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        chk_en = 1'b1;
        @(posedge clk_i); #1;

        // 8N1, div=3, 0x55
        set_cfg(3, 2'd3, 1'b0, 1'b0, 1'b0);
        push_word(8'h55);
        capture("t1", 40);
        check_frame("t1", 16'b0000_0010_1010_1010, 10, 4);
        @(negedge clk_i);
        check("t1_busy_end", int'(busy_o), 0);
        @(posedge clk_i); #1;

        // 7 bits, odd parity, 2 stop bits, 0x41; config changes mid-frame are ignored
        set_cfg(1, 2'd2, 1'b1, 1'b1, 1'b1);
        push_word(8'h41);
        fork
            capture("t2", 22);
            begin
                repeat (6) @(posedge clk_i); #1;
                set_cfg(7, 2'd3, 1'b0, 1'b0, 1'b0);
            end
        join
        check_frame("t2", 16'b0000_0111_1000_0010, 11, 2);
        @(negedge clk_i);
        check("t2_busy_end", int'(busy_o), 0);
        @(posedge clk_i); #1;

        // Assorted formats including div=0, compared against the model only
        set_cfg(0, 2'd0, 1'b1, 1'b0, 1'b0); push_word(8'h1F); wait_idle("t3a");
        set_cfg(2, 2'd1, 1'b0, 1'b0, 1'b1); push_word(8'hC3); wait_idle("t3b");
        set_cfg(1, 2'd3, 1'b1, 1'b1, 1'b0); push_word(8'h80); wait_idle("t3c");
        set_cfg(0, 2'd2, 1'b1, 1'b0, 1'b1); push_word(8'h7E); push_word(8'h01); wait_idle("t3d");

        // Fill: div=100, continuous pushes
        set_cfg(100, 2'd3, 1'b0, 1'b0, 1'b0);
        acc = 0;
        t_start = -1;
        for (int i = 0; i < 20; i++) begin
            tx_data_i  = 8'(8'hA0 + i);
            tx_valid_i = 1'b1;
            @(negedge clk_i);
            if (tx_ready_o) acc++;
            @(posedge clk_i); #1;
            if (busy_o && t_start < 0) t_start = cyc;
        end
        tx_valid_i = 1'b0;
        check("t4_accepted", acc, 9);
        check("t4_count_full", int'(fifo_count_o), 8);
        check("t4_ready_full", int'(tx_ready_o), 0);
        t_end = cyc;
        while (busy_o && (cyc - t_start) < 20000) begin
            @(posedge clk_i); #1;
            t_end = cyc;
        end
        check("t4_busy_span", t_end - t_start, 9 * 1010);
        wait_idle("t4");

        // Break held 50 cycles in IDLE, div=3
        set_cfg(3, 2'd3, 1'b0, 1'b0, 1'b0);
        zeros = 0;
        ones = 0;
        cfg_break_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_i); #1;
            if (!tx_o && busy_o) zeros++;
            if (i == 49) cfg_break_i = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            if (tx_o && busy_o) ones++;
        end
        check("t5_break_low", zeros, 50);
        check("t5_stop_high", ones, 4);
        @(posedge clk_i); #1;
        check("t5_idle_busy", int'(busy_o), 0);
        check("t5_idle_tx", int'(tx_o), 1);

        // Disable mid-DATA with 3 words queued, then re-enable
        tx_valid_i = 1'b1;
        tx_data_i = 8'h11; @(posedge clk_i); #1;
        tx_data_i = 8'h22; @(posedge clk_i); #1;
        tx_data_i = 8'h33; @(posedge clk_i); #1;
        tx_data_i = 8'h44; @(posedge clk_i); #1;
        tx_valid_i = 1'b0;
        repeat (6) @(posedge clk_i); #1;
        cfg_en_i = 1'b0;
        @(posedge clk_i); #1;
        check("t6_tx_high", int'(tx_o), 1);
        check("t6_busy", int'(busy_o), 0);
        check("t6_count", int'(fifo_count_o), 3);
        check("t6_ready", int'(tx_ready_o), 0);
        cfg_en_i = 1'b1;
        capture("t6", 40);
        check_frame("t6", 16'b0000_0010_0100_0100, 10, 4);
        wait_idle("t6");

        // Flush with simultaneous push during a frame
        tx_valid_i = 1'b1;
        tx_data_i = 8'h5A; @(posedge clk_i); #1;
        tx_data_i = 8'h3C; @(posedge clk_i); #1;
        tx_valid_i = 1'b0;
        repeat (5) @(posedge clk_i); #1;
        fifo_clr_i = 1'b1;
        tx_valid_i = 1'b1;
        tx_data_i  = 8'h99;
        @(posedge clk_i); #1;
        fifo_clr_i = 1'b0;
        tx_valid_i = 1'b0;
        check("t7_count_cleared", int'(fifo_count_o), 0);
        check("t7_frame_running", int'(busy_o), 1);
        wait_idle("t7");
        repeat (10) @(posedge clk_i); #1;
        check("t7_no_stored_push", int'(busy_o), 0);
        check("t7_empty", int'(tx_empty_o), 1);

        // Reset asserted mid-frame with words queued
        tx_valid_i = 1'b1;
        tx_data_i = 8'hAA; @(posedge clk_i); #1;
        tx_data_i = 8'hBB; @(posedge clk_i); #1;
        tx_data_i = 8'hCC; @(posedge clk_i); #1;
        tx_valid_i = 1'b0;
        repeat (8) @(posedge clk_i);
        @(negedge clk_i); #2;
        rstn_i = 1'b0;
        #1;
        check("t8_rst_tx", int'(tx_o), 1);
        check("t8_rst_busy", int'(busy_o), 0);
        check("t8_rst_count", int'(fifo_count_o), 0);
        check("t8_rst_empty", int'(tx_empty_o), 1);
        check("t8_rst_ready", int'(tx_ready_o), 1);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        repeat (5) @(posedge clk_i); #1;
        check("t8_after_busy", int'(busy_o), 0);
        check("t8_after_tx", int'(tx_o), 1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter DIV_W, default 16, baud divider width.
REQ-003 SHALL have port clk_i, input, 1, the block's single clock; all logic is rising-edge.
REQ-004 SHALL have port rstn_i, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port tx_o, output, 1, serial line; idle high.
REQ-006 SHALL have port busy_o, output, 1, high when the FSM is not IDLE.
REQ-007 SHALL have port cfg_en_i, input, 1, block enable.
REQ-008 SHALL have port cfg_div_i, input, DIV_W, bit period minus one, in clk_i cycles.
REQ-009 SHALL have ports cfg_parity_en_i (input, 1) and cfg_parity_odd_i (input, 1), the parity enable and the parity select (1 = odd, 0 = even).
REQ-010 SHALL have ports cfg_bits_i (input, 2; data bits = value+5) and cfg_stop_bits_i (input, 1; 1 = two stop bits).
REQ-011 SHALL have port cfg_break_i, input, 1, break request.
REQ-012 SHALL have ports tx_data_i (input, 8), tx_valid_i (input, 1) and tx_ready_o (output, 1), a valid/ready push interface.
REQ-013 SHALL have port fifo_clr_i, input, 1, synchronous FIFO flush.
REQ-014 SHALL have ports fifo_count_o (output, $clog2(FIFO_DEPTH)+1; FIFO occupancy) and tx_empty_o (output, 1; FIFO empty and FSM IDLE).

Function
REQ-015 SHALL drive tx_ready_o = cfg_en_i && !full, combinationally; a push occurs when tx_valid_i && tx_ready_o.
REQ-016 SHALL leave fifo_count_o unchanged on a cycle with both a push and a pop; count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-017 SHALL give fifo_clr_i priority: the FIFO empties, a same-cycle push is dropped, and an in-flight frame completes.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
REQ-019 SHALL pop in IDLE when cfg_en_i=1, the FIFO is non-empty and cfg_break_i=0; the next state is START.
REQ-020 SHALL latch, on every pop, the data word, cfg_div_i, cfg_bits_i, cfg_parity_en_i, cfg_parity_odd_i and cfg_stop_bits_i; config changes mid-frame SHALL have no effect on that frame.
REQ-021 SHALL hold every bit on tx_o for exactly latched_div+1 cycles; div=0 gives 1-cycle bits.
REQ-022 SHALL drive tx_o: START 0, DATA latched bits LSB first, PARITY parity bit, STOP1/STOP2 1.
REQ-023 SHALL follow DATA with PARITY if parity is enabled, else STOP1; PARITY SHALL be followed by STOP1.
REQ-024 SHALL compute parity as the XOR of transmitted data bits for even, inverted for odd.
REQ-025 SHALL leave STOP1 for STOP2 if two stop bits are latched, else end the frame; STOP2 SHALL end the frame.
REQ-026 At frame end, SHALL pop and enter START directly if the FIFO is non-empty, cfg_en_i=1 and cfg_break_i=0 (zero idle gap), else go to IDLE.
REQ-027 SHALL enter BREAK from IDLE when cfg_break_i=1; BREAK drives tx_o=0 while cfg_break_i is held, then enters STOP1 using the current cfg_div_i and one stop bit.
REQ-028 SHALL ignore cfg_break_i asserted mid-frame until frame end.
REQ-029 SHALL, when cfg_en_i=0, force the FSM to IDLE next cycle with tx_o=1; the in-flight word is lost and FIFO contents are retained.

Reset
REQ-030 SHALL, on rstn_i low, asynchronously clear the FSM to IDLE, the FIFO pointers and count to 0 and the baud counter to 0, and set the shift register to all ones.
REQ-031 During and after reset SHALL give: tx_o=1, busy_o=0, fifo_count_o=0, tx_empty_o=1, tx_ready_o=cfg_en_i.
REQ-032 SHALL abort any frame on reset assertion mid-frame, discard FIFO contents, and drive tx_o=1 immediately.

Verification
REQ-033 SHALL cover: 8N1, div=3, push 0x55 -> tx_o 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; 40-cycle frame; busy_o deasserts after it.
REQ-034 SHALL cover: 7 bits, odd parity, 2 stop bits, push 0x41 -> data 1,0,0,0,0,0,1, parity 1, two high stop bits.
REQ-035 SHALL cover: div=100, depth 8, continuous pushes -> 9 accepted (1 in flight plus 8 queued); tx_ready_o=0 and fifo_count_o=8; frames then back-to-back with no idle cycle.
REQ-036 SHALL cover: cfg_break_i high 50 cycles in IDLE -> tx_o=0 for 50 cycles, then 1 for div+1 cycles, then IDLE.
REQ-037 SHALL cover: cfg_en_i dropped mid-DATA with 3 words queued -> tx_o=1 and IDLE next cycle, fifo_count_o=3; re-enable sends the next word.
REQ-038 SHALL cover: fifo_clr_i with a simultaneous push during a frame -> count 0, current frame completes, push not stored.
